// File: rtl/i2s_pkg.sv
// Shared types for the I2S transmitter. I2S_LEFT_JUSTIFIED_EN selects left-justified
// slot placement instead of standard I2S.
package i2s_pkg;

  localparam int unsigned SAMPLE_W = 24;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Left occupies the upper half so the struct lines up with the 48-bit bus.
  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

  function automatic logic slot_has_data(input logic [5:0] k);
`ifdef I2S_LEFT_JUSTIFIED_EN
    return k < 6'(SAMPLE_W);
`else
    return (k >= 6'd1) && (k <= 6'(SAMPLE_W));
`endif
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK/LRCLK timing for the I2S transmitter: divider, bit counter and fall/wrap strobes.
// Built identically whether or not I2S_LEFT_JUSTIFIED_EN is defined.
module i2s_bclk_gen #(
  parameter int unsigned BCLK_DIV  = 8,
  parameter int unsigned SLOT_BITS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       bclk,
  output logic       lrclk,
  output logic       fall,
  output logic       wrap,
  output logic       right_next,
  output logic [5:0] slot_k
);

  localparam int unsigned DivW = $clog2(BCLK_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(BCLK_DIV - 1);
  localparam logic [5:0] BitMax = 6'(2 * SLOT_BITS - 1);
  localparam logic [5:0] SlotW = 6'(SLOT_BITS);

  logic [DivW-1:0] div_q;
  logic            bclk_q;
  logic            lrclk_q;
  logic [5:0]      bit_q;
  logic [5:0]      bit_nxt;
  logic            term;

  assign term       = (div_q == DivMax);
  assign fall       = term & bclk_q;
  assign wrap       = fall & (bit_q == BitMax);
  assign bit_nxt    = (bit_q == BitMax) ? 6'd0 : bit_q + 6'd1;
  assign right_next = (bit_nxt >= SlotW);
  // Strobes and slot position describe the bit that becomes current on this fall.
  assign slot_k     = right_next ? bit_nxt - SlotW : bit_nxt;
  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      bit_q   <= BitMax;
      lrclk_q <= 1'b1;
    end else if (term) begin
      div_q  <= '0;
      bclk_q <= ~bclk_q;
      if (bclk_q) begin
        bit_q   <= bit_nxt;
        lrclk_q <= right_next;
      end
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S master transmitter with a single holding register and underrun/overrun pulses.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified slot format.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned BCLK_DIV  = 8,
  parameter int unsigned SLOT_BITS = 32
) (
  input  logic        i_clk48,
  input  logic        i_rst48_n,
  input  logic [47:0] i_lr,
  input  logic        i_new_pulse,
  input  logic        i_mute,
  output logic        o_bclk,
  output logic        o_lrclk,
  output logic        o_sdata,
  output logic        o_frame_start,
  output logic        o_underrun,
  output logic        o_overrun
);

  logic       fall;
  logic       wrap;
  logic       right_next;
  logic [5:0] slot_k;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV),
    .SLOT_BITS(SLOT_BITS)
  ) u_bclk_gen (
    .clk       (i_clk48),
    .rst_n     (i_rst48_n),
    .bclk      (o_bclk),
    .lrclk     (o_lrclk),
    .fall      (fall),
    .wrap      (wrap),
    .right_next(right_next),
    .slot_k    (slot_k)
  );

  stereo_t hold_q;
  logic    hold_valid_q;
  sample_t left_sr_q;
  sample_t right_sr_q;
  logic    sdata_q;
  logic    frame_start_q;
  logic    underrun_q;
  logic    overrun_q;

  stereo_t frame;
  sample_t cur_left;
  sample_t cur_right;

  // On the load fall the outgoing bit comes straight from the new frame, not the old shifter.
  always_comb begin
    frame     = i_mute ? '0 : hold_q;
    cur_left  = wrap ? frame.left : left_sr_q;
    cur_right = wrap ? frame.right : right_sr_q;
  end

  always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
    if (!i_rst48_n) begin
      hold_q        <= '0;
      hold_valid_q  <= 1'b0;
      left_sr_q     <= '0;
      right_sr_q    <= '0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      frame_start_q <= wrap;
      underrun_q    <= wrap & ~hold_valid_q;
      overrun_q     <= i_new_pulse & hold_valid_q & ~wrap;

      if (i_new_pulse) begin
        hold_q       <= i_lr;
        hold_valid_q <= 1'b1;
      end else if (wrap) begin
        hold_valid_q <= 1'b0;
      end

      if (fall) begin
        left_sr_q  <= cur_left;
        right_sr_q <= cur_right;
        if (slot_has_data(slot_k)) begin
          if (right_next) begin
            sdata_q    <= cur_right[SAMPLE_W-1];
            right_sr_q <= {cur_right[SAMPLE_W-2:0], 1'b0};
          end else begin
            sdata_q   <= cur_left[SAMPLE_W-1];
            left_sr_q <= {cur_left[SAMPLE_W-2:0], 1'b0};
          end
        end else begin
          sdata_q <= 1'b0;
        end
      end
    end
  end

  assign o_sdata       = sdata_q;
  assign o_frame_start = frame_start_q;
  assign o_underrun    = underrun_q;
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: frame scoreboard fed by the stimulus tasks, plus flag and
// timing checks. Honours I2S_LEFT_JUSTIFIED_EN for the expected slot layout.
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int unsigned BCLK_DIV  = 8;
  localparam int unsigned SLOT_BITS = 32;
  localparam int unsigned FB        = 2 * SLOT_BITS;
  localparam int unsigned FRAME_CYC = FB * 2 * BCLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] lr = '0;
  logic        new_pulse = 1'b0;
  logic        mute = 1'b0;
  logic        bclk, lrclk, sdata, frame_start, underrun, overrun;

  i2s_tx #(
    .BCLK_DIV (BCLK_DIV),
    .SLOT_BITS(SLOT_BITS)
  ) dut (
    .i_clk48      (clk),
    .i_rst48_n    (rst_n),
    .i_lr         (lr),
    .i_new_pulse  (new_pulse),
    .i_mute       (mute),
    .o_bclk       (bclk),
    .o_lrclk      (lrclk),
    .o_sdata      (sdata),
    .o_frame_start(frame_start),
    .o_underrun   (underrun),
    .o_overrun    (overrun)
  );

  always #5 clk = ~clk;

  int      n_cmp = 0;
  int      n_bad = 0;
  int      ur_cnt = 0;
  int      ov_cnt = 0;
  stereo_t sb[$];

  function automatic logic [FB-1:0] exp_bits(input stereo_t f);
    logic [FB-1:0] v;
    sample_t s;
    int k;
    v = '0;
    for (int p = 0; p < int'(FB); p++) begin
      k = p % int'(SLOT_BITS);
      s = (p < int'(SLOT_BITS)) ? f.left : f.right;
`ifdef I2S_LEFT_JUSTIFIED_EN
      if (k < 24) v[FB-1-p] = s[23-k];
`else
      if (k >= 1 && k <= 24) v[FB-1-p] = s[24-k];
`endif
    end
    return v;
  endfunction

  // Monitor: reassembles each frame from BCLK-rise samples and checks it against the scoreboard.
  int            pos = 0;
  bit            collecting = 0;
  bit            lr_bad = 0;
  logic          prev_bclk = 1'b0;
  logic [FB-1:0] got = '0;
  logic [FB-1:0] want;

  always @(negedge clk) begin
    if (!rst_n) begin
      collecting = 0;
      prev_bclk  = 1'b0;
    end else begin
      if (overrun) ov_cnt++;
      if (underrun) ur_cnt++;
      if (frame_start) begin
        collecting = 1;
        pos        = 0;
        lr_bad     = 0;
      end
      if (bclk && !prev_bclk && collecting) begin
        got[FB-1-pos] = sdata;
        if (lrclk !== (pos >= int'(SLOT_BITS))) lr_bad = 1;
        pos++;
        if (pos == int'(FB)) begin
          collecting = 0;
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL frame_unexpected: got %h, required no frame", got);
          end else begin
            want = exp_bits(sb.pop_front());
            if (got !== want || lr_bad) begin
              n_bad++;
              $display("FAIL frame_data: got %h lr_err=%0b, required %h lr_err=0",
                       got, lr_bad, want);
            end
          end
        end
      end
      prev_bclk = bclk;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 2000; i++) begin
      step();
      if (frame_start === 1'b1) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_frame_start: got timeout, required frame_start within 2000 cycles");
  endtask

  task automatic startup_check();
    logic [3:0] e, g;
    sb.push_back('0);
    step();
    rst_n = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      step();
      e = {(n >= 8 && n < 16), (n < 16), (n == 16), (n == 16)};
      g = {bclk, lrclk, frame_start, underrun};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL startup_c%0d: got bclk/lr/fs/ur=%b, required %b", n, g, e);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({bclk, lrclk, sdata, frame_start, underrun, overrun} !== 6'b010000) begin
      n_bad++;
      $display("FAIL reset_values: got %b, required 010000",
               {bclk, lrclk, sdata, frame_start, underrun, overrun});
    end
    startup_check();
  endtask

  task automatic test_basic();
    int u0, o0;
    u0 = ur_cnt;
    o0 = ov_cnt;
    lr = 48'hABCDEF_123456;
    new_pulse = 1'b1;
    sb.push_back(stereo_t'(48'hABCDEF_123456));
    step();
    new_pulse = 1'b0;
    wait_fs();
    #1;
    n_cmp++;
    if (ur_cnt - u0 != 0 || ov_cnt - o0 != 0) begin
      n_bad++;
      $display("FAIL basic_flags: got ur=%0d ov=%0d, required 0 0", ur_cnt - u0, ov_cnt - o0);
    end
  endtask

  task automatic test_retransmit();
    int u0;
    for (int f = 0; f < 2; f++) begin
      sb.push_back(stereo_t'(48'hABCDEF_123456));
      u0 = ur_cnt;
      wait_fs();
      #1;
      n_cmp++;
      if (ur_cnt - u0 != 1) begin
        n_bad++;
        $display("FAIL underrun_per_frame%0d: got %0d, required 1", f, ur_cnt - u0);
      end
    end
  endtask

  task automatic test_overrun();
    int u0, o0;
    u0 = ur_cnt;
    o0 = ov_cnt;
    sb.push_back(stereo_t'(48'h7FFFFF_800000));
    for (int n = 1; n <= 30; n++) begin
      step();
      if (n == 5) begin lr = 48'h000001_000002; new_pulse = 1'b1; end
      if (n == 6) new_pulse = 1'b0;
      if (n == 20) begin lr = 48'h7FFFFF_800000; new_pulse = 1'b1; end
      if (n == 21) new_pulse = 1'b0;
    end
    wait_fs();
    #1;
    n_cmp++;
    if (ov_cnt - o0 != 1 || ur_cnt - u0 != 0) begin
      n_bad++;
      $display("FAIL overrun_once: got ov=%0d ur=%0d, required 1 0", ov_cnt - o0, ur_cnt - u0);
    end
    // Second strobe lands in the exact load cycle.
    u0 = ur_cnt;
    o0 = ov_cnt;
    sb.push_back(stereo_t'(48'h111111_222222));
    sb.push_back(stereo_t'(48'h333333_444444));
    for (int n = 1; n <= int'(FRAME_CYC); n++) begin
      step();
      if (n == 5) begin lr = 48'h111111_222222; new_pulse = 1'b1; end
      if (n == 6) new_pulse = 1'b0;
      if (n == int'(FRAME_CYC) - 1) begin lr = 48'h333333_444444; new_pulse = 1'b1; end
      if (n == int'(FRAME_CYC)) begin
        new_pulse = 1'b0;
        n_cmp++;
        if (frame_start !== 1'b1) begin
          n_bad++;
          $display("FAIL load_cycle_fs: got %b, required 1", frame_start);
        end
      end
    end
    wait_fs();
    #1;
    n_cmp++;
    if (ov_cnt - o0 != 0 || ur_cnt - u0 != 0) begin
      n_bad++;
      $display("FAIL load_collision_flags: got ov=%0d ur=%0d, required 0 0",
               ov_cnt - o0, ur_cnt - u0);
    end
  endtask

  task automatic test_mute();
    int u0;
    u0 = ur_cnt;
    sb.push_back('0);
    for (int n = 1; n <= int'(FRAME_CYC); n++) begin
      step();
      if (n == 5) begin lr = 48'h555555_666666; new_pulse = 1'b1; end
      if (n == 6) new_pulse = 1'b0;
      if (n == 1000) mute = 1'b1;
      if (n == int'(FRAME_CYC)) begin
        mute = 1'b0;
        n_cmp++;
        if (frame_start !== 1'b1) begin
          n_bad++;
          $display("FAIL mute_load_fs: got %b, required 1", frame_start);
        end
      end
    end
    #1;
    n_cmp++;
    if (ur_cnt - u0 != 0) begin
      n_bad++;
      $display("FAIL mute_no_underrun: got %0d, required 0", ur_cnt - u0);
    end
    // Mute pulsed mid-frame must leave the frame in flight intact.
    u0 = ur_cnt;
    sb.push_back(stereo_t'(48'h555555_666666));
    for (int n = 1; n <= int'(FRAME_CYC); n++) begin
      step();
      if (n == 200) mute = 1'b1;
      if (n == 600) mute = 1'b0;
    end
    #1;
    n_cmp++;
    if (ur_cnt - u0 != 1 || frame_start !== 1'b1) begin
      n_bad++;
      $display("FAIL mute_clears_valid: got ur=%0d fs=%b, required 1 1", ur_cnt - u0, frame_start);
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 1; n <= 300; n++) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bclk, lrclk, sdata, frame_start, underrun, overrun} !== 6'b010000) begin
      n_bad++;
      $display("FAIL async_reset: got %b, required 010000",
               {bclk, lrclk, sdata, frame_start, underrun, overrun});
    end
    sb.delete();
    repeat (3) step();
    startup_check();
  endtask

  task automatic test_drain();
    for (int i = 0; i < 1500 && sb.size() != 0; i++) step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retransmit();
    test_overrun();
    test_mute();
    test_reset_mid();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
